// File: rtl/product_display_pkg.sv
// -----------------------------------------------------------------------------
// product_display_pkg
// Shared definitions for the product BCD display path:
//   - state_t        : control FSM states (IDLE, CONV, UPDATE)
//   - SEG_*          : 7-bit segment glyphs, bit order {g,f,e,d,c,b,a}, active high
//   - DIG_*          : scan index of each display digit (0 = ones, 3 = sign)
//   - BCD_ITERATIONS : double-dabble iterations for an 8-bit binary input
//   - bcd_glyph()    : maps one BCD digit to its segment glyph
// -----------------------------------------------------------------------------
package product_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_SIGN     = 2'd3;

    localparam int BCD_ITERATIONS = 8;

    // Non-decimal codes cannot come out of the converter; they map to blank
    // so a corrupted digit never shows a misleading number.
    function automatic logic [6:0] bcd_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    bcd_glyph = SEG_0;
            4'd1:    bcd_glyph = SEG_1;
            4'd2:    bcd_glyph = SEG_2;
            4'd3:    bcd_glyph = SEG_3;
            4'd4:    bcd_glyph = SEG_4;
            4'd5:    bcd_glyph = SEG_5;
            4'd6:    bcd_glyph = SEG_6;
            4'd7:    bcd_glyph = SEG_7;
            4'd8:    bcd_glyph = SEG_8;
            4'd9:    bcd_glyph = SEG_9;
            default: bcd_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin8_to_bcd3.sv
// -----------------------------------------------------------------------------
// bin8_to_bcd3
// Sequential double-dabble converter: 8-bit binary -> three BCD digits.
// One iteration (add 3 to every BCD nibble >= 5, then shift left by one) is
// performed per clock, so a conversion takes BCD_ITERATIONS cycles after start.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   1-cycle strobe: capture bin and begin a conversion
//   bin       in   8-bit binary value (0..255)
//   done      out  high during the final iteration; results are valid from
//                  the following cycle and held until the next start
//   hundreds  out  BCD hundreds digit (0..2)
//   tens      out  BCD tens digit
//   ones      out  BCD ones digit
// -----------------------------------------------------------------------------
module bin8_to_bcd3
    import product_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [2:0] LAST_ITER = 3'(BCD_ITERATIONS - 1);

    logic [7:0]  shift_q;   // binary bits still to be shifted in, MSB first
    logic [11:0] bcd_q;     // {hundreds, tens, ones}
    logic [2:0]  iter_q;
    logic        active_q;
    logic [11:0] bcd_adj;

    // NOTE: every variable assigned in an always_comb gets a default value
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = active_q && (iter_q == LAST_ITER);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            iter_q   <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            iter_q   <= '0;
            shift_q  <= bin;
            bcd_q    <= '0;
        end else if (active_q) begin
            // The hundreds nibble never exceeds 2, so dropping bit 11 of the
            // adjusted value loses nothing.
            {bcd_q, shift_q} <= {bcd_adj[10:0], shift_q, 1'b0};
            iter_q           <= iter_q + 3'd1;
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

    assign hundreds = bcd_q[11:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];

endmodule

// File: rtl/product_bcd_display.sv
// -----------------------------------------------------------------------------
// product_bcd_display
// Captures the multiplier product on a load strobe, converts it (signed or
// unsigned) to sign + three BCD digits and scans the result onto a 4-digit
// 7-segment display.
// Parameters:
//   SCAN_DIV        clock cycles each digit stays enabled (>= 2)
//   SEG_ACTIVE_LOW  1: invert seg at the output register (common-anode boards)
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   product_in   in   8-bit product
//   signed_mode  in   1: product_in is two's complement, 0: unsigned
//   load         in   1-cycle capture strobe, ignored while busy
//   busy         out  conversion in progress (CONV or UPDATE)
//   bcd_valid    out  1-cycle pulse while new digits are written to the display
//   seg          out  {g,f,e,d,c,b,a} of the enabled digit
//   digit_en     out  one-hot digit enable, bit0 = ones, bit3 = sign
// Timing: load in cycle N -> CONV in N+1..N+8 -> UPDATE and bcd_valid in N+9.
// -----------------------------------------------------------------------------
module product_bcd_display
    import product_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] product_in,
    input  logic       signed_mode,
    input  logic       load,
    output logic       busy,
    output logic       bcd_valid,
    output logic [6:0] seg,
    output logic [3:0] digit_en
);

    localparam int                SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_MASK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // ---------------------------------------------------------------- control
    state_t state_q, state_d;
    logic   start;
    logic   conv_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        busy      = 1'b0;
        bcd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    start   = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (conv_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy      = 1'b1;
                bcd_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------ sign / magnitude
    // A signed zero has bit 7 clear, so it can never come out negative; the
    // magnitude of -128 is 128, which still fits the 8-bit unsigned range.
    logic       neg_in;
    logic [7:0] mag_in;
    logic       neg_q;

    assign neg_in = signed_mode & product_in[7];
    assign mag_in = neg_in ? (~product_in + 8'd1) : product_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (start) begin
            neg_q <= neg_in;
        end
    end

    logic [3:0] conv_hundreds, conv_tens, conv_ones;

    bin8_to_bcd3 u_bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (mag_in),
        .done     (conv_done),
        .hundreds (conv_hundreds),
        .tens     (conv_tens),
        .ones     (conv_ones)
    );

    // ------------------------------------------------------ display registers
    logic       disp_neg;
    logic [3:0] disp_hundreds, disp_tens, disp_ones;

    // NOTE: these hold what the user sees, so they are reset to a defined
    // value (positive zero) rather than left to power up as garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_neg      <= 1'b0;
            disp_hundreds <= '0;
            disp_tens     <= '0;
            disp_ones     <= '0;
        end else if (state_q == UPDATE) begin
            disp_neg      <= neg_q;
            disp_hundreds <= conv_hundreds;
            disp_tens     <= conv_tens;
            disp_ones     <= conv_ones;
        end
    end

    // ------------------------------------------------------------------ scan
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        scan_idx_q;
    logic [1:0]        scan_idx_next;
    logic              scan_tc;
    logic [6:0]        glyph;

    assign scan_tc       = (scan_cnt_q == SCAN_LAST);
    assign scan_idx_next = scan_tc ? scan_idx_q + 2'd1 : scan_idx_q;

    // The glyph is chosen for the index that will be active after this edge,
    // so seg and digit_en switch together in the same registered update.
    always_comb begin
        glyph = SEG_BLANK;
        case (scan_idx_next)
            DIG_ONES:     glyph = bcd_glyph(disp_ones);
            DIG_TENS:     glyph = (disp_tens == 4'd0 && disp_hundreds == 4'd0)
                                  ? SEG_BLANK : bcd_glyph(disp_tens);
            DIG_HUNDREDS: glyph = (disp_hundreds == 4'd0)
                                  ? SEG_BLANK : bcd_glyph(disp_hundreds);
            DIG_SIGN:     glyph = disp_neg ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= DIG_ONES;
            digit_en   <= 4'b0001;
            seg        <= SEG_0 ^ SEG_MASK;
        end else begin
            scan_cnt_q <= scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
            scan_idx_q <= scan_idx_next;
            if (scan_tc) begin
                digit_en <= {digit_en[2:0], digit_en[3]};
            end
            seg <= glyph ^ SEG_MASK;
        end
    end

endmodule
